r2sdf_stage: RTL and testbench
==============================

// Module: r2sdf_stage
// PURPOSE
//  One parametrised fixed-point radix-2 single-delay-feedback (R2SDF) decimation-in-frequency (DIF) butterfly stage.
//  - Input: a serial complex stream. Output: the serial stream after this stage's butterfly and twiddle rotation.
//  - Cascading N instances, STAGE = 0..N-1, builds a 2^N-point pipelined FFT.
//  - Replaces the real-valued, fixed-size, unclocked-handshake FFT model with a synthesizable stage.
//  - Adds: valid-qualified stalls, frame resync and selectable scaling/saturation.
// PARAMETERS
//  N     4   log2 of FFT size; valid range 1..12
//  STAGE 0   stage index, 0..N-1; delay length L = 2^(N-1-STAGE)
//  DW    16  signed data width of each of re/im, in and out
//  TW    16  signed twiddle width, Q1.(TW-1)
//  SCALE 1   1: butterfly result >>>1 (truncate); 0: no shift, saturate to DW
// PORTS
//  clk      in  1   rising-edge clock
//  rst_n    in  1   synchronous active-low reset
//  in_valid in  1   input sample qualifier; low = stall
//  in_sync  in  1   with in_valid: this sample is frame index 0
//  in_re    in  DW  signed real part
//  in_im    in  DW  signed imaginary part
//  out_valid out 1  output qualifier
//  out_re   out DW  signed real part
//  out_im   out DW  signed imaginary part
// BEHAVIOUR
//  - Reset, rst_n low at an edge: cnt=0, primed=0, out_valid=0, out_re=out_im=0. The delay line is not reset.
//  - Counter and phases:
//    - cnt is (N-STAGE) bits and advances by 1 per in_valid sample, wrapping at 2L.
//    - Phase A: cnt<L. Phase B: cnt>=L.
//    - in_sync & in_valid forces that sample's index to 0 (next cnt=1) and clears primed.
//  - Phase A, per valid sample:
//    - The delay line pushes in and pops head h.
//    - The output is h*W^(k*2^STAGE) for FFT size 2^N, with k=cnt.
//    - k=0, and every sample when STAGE=N-1, bypasses the multiplier and outputs exactly h.
//  - Phase B, per valid sample:
//    - Output s = h+in.
//    - The delay line pushes d = h-in.
//    - primed is set on the first phase-B sample.
//  - Width rules:
//    - Sums and differences are formed at DW+1 bits, then SCALE=1 applies an arithmetic >>>1, or SCALE=0 saturates to [-2^(DW-1), 2^(DW-1)-1].
//    - The complex multiply is 4 real products at DW+TW bits.
//    - Each product sum is rounded by adding 2^(TW-2), shifted >>>(TW-1), then saturated to DW.
//    - The twiddle ROM stores cos and -sin, with +1.0 clipped to 2^(TW-1)-1.
//  - Latency: out_re/out_im/out_valid register 1 clk after the valid input sample that produces them.
//  - out_valid = registered (in_valid & (primed | phase B)). It stays 0 through the first phase A after reset or sync.
//  - Stall: in_valid=0 freezes cnt, the delay line and primed; out_valid drops to 0 next clk; out_re/out_im hold their last value.
//  - Simultaneous events:
//    - rst_n low overrides in_sync and in_valid.
//    - in_sync overrides the counter wrap.
//    - Reset mid-frame discards partial data; outputs are clean from the first post-reset phase B.
// STRUCTURE
//  - fft_pkg holds:
//    - typedef cplx_t {logic signed [DW-1:0] re, im}
//    - function clog2-based delay length
//    - sat/round helper functions
//    - the SCALE encoding constants.
//  - One sub-module, r2sdf_twiddle_rom #(N,STAGE,TW): combinational lookup from k to {cos,-sin}, built at elaboration time from $cos/$sin.
//  - Delay line: a register shift chain or circular RAM of depth L.
//  - Butterfly, multiplier and output register stay in this module.
// TESTING
//  All tests use N=4, STAGE=0, DW=TW=16, SCALE=1 (L=8) unless noted.
//  1. Impulse: frame1 x0=1000, rest 0, then frame2 all 0.
//     - Frame1 phase-B outputs: 500, then 7 zeros.
//     - Frame2 phase-A outputs: 500, then 7 zeros.
//  2. Twiddle: frame1 x2=1000, rest 0.
//     - Next phase A, k=2: out=(354,-354) ±1 LSB.
//     - All other k give 0.
//  3. Constant 1000+0j over 2 frames.
//     - Sums = 1000.
//     - Diffs = 0.
//     - out_valid low during the first 8 samples and high afterwards.
//  4. Stall: deassert in_valid for 3 clk mid-phase-B.
//     - out_valid 0 for those 3 clk.
//     - Output sequence identical to test 3 once resumed, no sample lost.
//  5. Sync/reset: pulse in_sync at sample 5; separately, rst_n low for 1 clk at sample 11.
//     - Both cases: cnt restarts at 0, out_valid low for the next 8 valid samples.
//     - Subsequent outputs match a fresh run.
//  6. SCALE=0: x0=x8=32767.
//     - Sum saturates to 32767.
//     - Diff = 0.
//     - x0=-32768 with x8=32767 gives diff -65535, which saturates to -32768.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, constants and arithmetic helpers for the R2SDF FFT stages.
package fft_pkg;

    // Butterfly scaling modes
    localparam int SCALE_SAT   = 0;  // no shift, saturate to the data width
    localparam int SCALE_SHIFT = 1;  // arithmetic shift right by one (truncate)

    // Reference complex sample at the default data width
    localparam int CPLX_DW = 16;
    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } cplx_t;

    // Wide signed container so helpers work for any DW/TW up to 31 bits
    typedef logic signed [63:0] wide_t;

    // Delay length of a stage: half the sub-FFT it spans
    function automatic int delay_len(input int n, input int stage);
        return 1 << (n - 1 - stage);
    endfunction

    // Counter width covering one full phase A + phase B period (2L)
    function automatic int cnt_bits(input int l);
        return $clog2(2 * l);
    endfunction

    // Clamp v to the signed range of a w-bit word
    function automatic wide_t sat_w(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Round-half-up then drop frac fractional bits
    function automatic wide_t round_shift(input wide_t v, input int frac);
        return (v + (wide_t'(1) <<< (frac - 1))) >>> frac;
    endfunction

    // Butterfly output conditioning: halve or saturate
    function automatic wide_t bfly_scale(input wide_t v, input int scale, input int w);
        if (scale == SCALE_SHIFT) return v >>> 1;
        return sat_w(v, w);
    endfunction

endpackage

// File: rtl/r2sdf_twiddle_rom.sv
// Twiddle lookup for one R2SDF stage: k -> {cos, -sin} of 2*pi*k*2^STAGE/2^N.
module r2sdf_twiddle_rom #(
    parameter int N     = 4,
    parameter int STAGE = 0,
    parameter int TW    = 16
) (
    input  logic [N-STAGE-1:0]  k_i,
    output logic signed [TW-1:0] cos_o,
    output logic signed [TW-1:0] msin_o
);
    localparam int  ENTRIES = 1 << (N - STAGE);
    localparam real PI      = 3.14159265358979323846;

    // Quantise to Q1.(TW-1); +1.0 does not fit and is clipped to the max code
    function automatic logic signed [TW-1:0] quant(input real x);
        longint q;
        longint qmax;
        qmax = (longint'(1) << (TW - 1)) - 1;
        q = longint'(x * real'(qmax + 1));
        if (q > qmax) q = qmax;
        if (q < -qmax - 1) q = -qmax - 1;
        return q[TW-1:0];
    endfunction

    logic signed [TW-1:0] cos_tab  [ENTRIES];
    logic signed [TW-1:0] msin_tab [ENTRIES];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_tab
        localparam real ANG = 2.0 * PI * real'(i * (1 << STAGE)) / real'(ENTRIES << STAGE);
        assign cos_tab[i]  = quant($cos(ANG));
        assign msin_tab[i] = quant(-$sin(ANG));
    end

    assign cos_o  = cos_tab[k_i];
    assign msin_o = msin_tab[k_i];

endmodule

// File: rtl/r2sdf_stage.sv
// One radix-2 single-delay-feedback DIF stage with valid-qualified stalls,
// frame resync and selectable scaling.
module r2sdf_stage
    import fft_pkg::*;
#(
    parameter int N     = 4,
    parameter int STAGE = 0,
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int SCALE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sync,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im
);
    localparam int L  = delay_len(N, STAGE);
    localparam int KW = cnt_bits(L);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } samp_t;

    logic [KW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    logic          out_valid_q, out_valid_d;
    samp_t         out_q, out_d;
    samp_t         dly_q [L];
    samp_t         dly_d [L];

    logic [KW-1:0]        idx;
    logic                 phase_b;
    logic                 primed_eff;
    samp_t                x, h, bf_sum, bf_dif, rot;
    logic signed [TW-1:0] tw_cos, tw_msin;

    // A sync sample is frame index 0 regardless of where the counter was
    assign idx        = in_sync ? '0 : cnt_q;
    assign phase_b    = idx[KW-1];
    assign primed_eff = in_sync ? 1'b0 : primed_q;
    assign x          = '{re: in_re, im: in_im};
    assign h          = dly_q[L-1];

    r2sdf_twiddle_rom #(.N(N), .STAGE(STAGE), .TW(TW)) u_rom (
        .k_i    (idx),
        .cos_o  (tw_cos),
        .msin_o (tw_msin)
    );

    // Butterfly: h+in goes out, h-in goes back into the delay line
    always_comb begin
        wide_t s_re, s_im, d_re, d_im;
        s_re = bfly_scale(wide_t'(h.re) + wide_t'(x.re), SCALE, DW);
        s_im = bfly_scale(wide_t'(h.im) + wide_t'(x.im), SCALE, DW);
        d_re = bfly_scale(wide_t'(h.re) - wide_t'(x.re), SCALE, DW);
        d_im = bfly_scale(wide_t'(h.im) - wide_t'(x.im), SCALE, DW);
        bf_sum.re = s_re[DW-1:0];
        bf_sum.im = s_im[DW-1:0];
        bf_dif.re = d_re[DW-1:0];
        bf_dif.im = d_im[DW-1:0];
    end

    // Twiddle rotation h * (cos + j*(-sin)), rounded and saturated back to DW
    always_comb begin
        logic signed [DW+TW-1:0] p_rc, p_ims, p_rms, p_ic;
        wide_t t_re, t_im;
        p_rc  = h.re * tw_cos;
        p_ims = h.im * tw_msin;
        p_rms = h.re * tw_msin;
        p_ic  = h.im * tw_cos;
        t_re  = sat_w(round_shift(wide_t'(p_rc) - wide_t'(p_ims), TW - 1), DW);
        t_im  = sat_w(round_shift(wide_t'(p_rms) + wide_t'(p_ic), TW - 1), DW);
        rot.re = t_re[DW-1:0];
        rot.im = t_im[DW-1:0];
    end

    // Per-sample sequencing: counter, priming, delay-line push and output select
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        dly_d       = dly_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            cnt_d    = idx + 1'b1;
            primed_d = primed_eff;
            for (int i = L - 1; i > 0; i--) dly_d[i] = dly_q[i-1];
            if (phase_b) begin
                dly_d[0]    = bf_dif;
                out_d       = bf_sum;
                out_valid_d = 1'b1;
                primed_d    = 1'b1;
            end else begin
                dly_d[0]    = x;
                out_d       = (idx == '0 || STAGE == N - 1) ? h : rot;
                out_valid_d = primed_eff;
            end
        end
    end

    // Control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Delay line keeps its contents through reset but does not shift during it
    always_ff @(posedge clk) begin
        if (rst_n) dly_q <= dly_d;
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_q.re;
    assign out_im    = out_q.im;

endmodule

// File: tb/tb_r2sdf_stage.sv
module tb_r2sdf_stage;
  localparam int N = 4;
  localparam int STAGE = 0;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int L = 8;
  localparam real PI = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance, SCALE=1
  logic in_valid = 1'b0, in_sync = 1'b0;
  logic signed [DW-1:0] in_re = '0, in_im = '0;
  logic out_valid;
  logic signed [DW-1:0] out_re, out_im;

  // saturating instance, SCALE=0
  logic s_valid = 1'b0, s_sync = 1'b0;
  logic signed [DW-1:0] s_re = '0, s_im = '0;
  logic s_out_valid;
  logic signed [DW-1:0] s_out_re, s_out_im;

  r2sdf_stage #(.N(N), .STAGE(STAGE), .DW(DW), .TW(TW), .SCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_re(out_re), .out_im(out_im)
  );

  r2sdf_stage #(.N(N), .STAGE(STAGE), .DW(DW), .TW(TW), .SCALE(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_sync(s_sync),
    .in_re(s_re), .in_im(s_im), .out_valid(s_out_valid), .out_re(s_out_re), .out_im(s_out_im)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [2*DW-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    int d;
    n_chk++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is 2L samples: first half is stored, second half combines with the
  // stored half (sum out, difference stored) and the stored differences then
  // leave during the next first half multiplied by exp(-j*2*pi*k/2^N).
  typedef struct { int re; int im; } mc_t;
  mc_t m_dq[$];
  int  m_cnt, m_re, m_im;
  bit  m_primed, m_known, m_v, m_tol;

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_primed = 0; m_known = 1; m_v = 0; m_tol = 0; m_re = 0; m_im = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input int xr, input int xi);
    int idx;
    mc_t h;
    real th;
    m_v = 0;
    if (!v) return;
    idx = m_cnt;
    if (s) begin idx = 0; m_primed = 0; end
    h = m_dq.pop_front();
    if (idx < L) begin
      m_dq.push_back('{xr, xi});
      if (idx == 0) begin
        m_re = h.re; m_im = h.im; m_tol = 0;
      end else begin
        th = 2.0 * PI * real'(idx) / real'(1 << N);
        m_re = clamp(int'(real'(h.re) * $cos(th) + real'(h.im) * $sin(th)));
        m_im = clamp(int'(real'(h.im) * $cos(th) - real'(h.re) * $sin(th)));
        m_tol = 1;
      end
      m_v = m_primed;
      m_known = m_primed;
    end else begin
      m_re = (h.re + xr) >>> 1;
      m_im = (h.im + xi) >>> 1;
      m_dq.push_back('{(h.re - xr) >>> 1, (h.im - xi) >>> 1});
      m_v = 1; m_primed = 1; m_known = 1; m_tol = 0;
    end
    m_cnt = (idx + 1) % (2 * L);
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input bit v, input bit s, input int xr, input int xi);
    @(negedge clk);
    rst_n = 1'b1; in_valid = v; in_sync = s; in_re = 16'(xr); in_im = 16'(xi);
    s_valid = 1'b0; s_sync = 1'b0;
    @(posedge clk);
    #1;
    model_step(v, s, xr, xi);
    chk("model_valid", out_valid, m_v);
    if (m_known) begin
      chk_tol("model_re", out_re, m_re, m_tol ? 1 : 0);
      chk_tol("model_im", out_im, m_im, m_tol ? 1 : 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_sync = 1'b1; in_re = 16'sd1234; in_im = -16'sd77;
    s_valid = 1'b1; s_sync = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    chk("rst_sat_valid", s_out_valid, 0);
  endtask

  task automatic cycle_s(input bit v, input bit s, input int xr);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_sync = 1'b0;
    s_valid = v; s_sync = s; s_re = 16'(xr); s_im = '0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  typedef struct { bit v; bit s; int xr; int xi; bit ev; int er; int ei; } vec_t;
  vec_t tbl[32];
  int sat_x[33];
  logic [2*DW-1:0] e;

  initial begin
    for (int i = 0; i < L; i++) m_dq.push_back('{0, 0});

    // impulse table: x0=1000 then an all-zero frame
    for (int i = 0; i < 32; i++)
      tbl[i] = '{1'b1, (i == 0), (i == 0) ? 1000 : 0, 0,
                 (i >= 8), (i == 8 || i == 16) ? 500 : 0, 0};

    do_reset();
    for (int i = 0; i < 32; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].xr, tbl[i].xi);
      chk("impulse_valid", out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("impulse_re", out_re, tbl[i].er);
        chk("impulse_im", out_im, tbl[i].ei);
      end
    end

    // twiddle: x2=1000 comes back at k=2 rotated by -pi/4
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, i == 0, (i == 2) ? 1000 : 0, 0);
      if (i == 10) chk("tw_sum_re", out_re, 500);
      if (i >= 16) begin
        chk_tol("tw_re", out_re, (i == 18) ? 354 : 0, 1);
        chk_tol("tw_im", out_im, (i == 18) ? -354 : 0, 1);
      end
    end

    // constant input: expected valid-output stream built from the rules
    for (int i = 8; i < 32; i++)
      exp_q.push_back({((i % 16) >= 8) ? 16'sd1000 : 16'sd0, 16'sd0});

    do_reset();
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, i == 0, 1000, 0);
      chk("const_valid", out_valid, (i >= 8) ? 1 : 0);
      if (out_valid) begin
        e = exp_q.pop_front();
        exp_q.push_back(e);
        chk("const_re", out_re, int'($signed(e[2*DW-1:DW])));
        chk("const_im", out_im, int'($signed(e[DW-1:0])));
      end
    end

    // same stream with a 3-cycle stall inside phase B
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, i == 0, 1000, 0);
      if (out_valid) begin
        e = exp_q.pop_front();
        exp_q.push_back(e);
        chk("stall_re", out_re, int'($signed(e[2*DW-1:DW])));
      end
      if (i == 11) begin
        for (int j = 0; j < 3; j++) begin
          cycle(1'b0, 1'b0, 0, 0);
          chk("stall_valid", out_valid, 0);
          chk("stall_hold", out_re, 1000);
        end
      end
    end

    // resync at sample 5
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, i == 0 || i == 5, 1000, 0);
      if (i >= 5) chk("sync_valid", out_valid, (i >= 13) ? 1 : 0);
      if (i >= 13 && i < 21) chk("sync_re", out_re, 1000);
    end

    // reset at sample 11
    do_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, i == 0, 1000, 0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1000, 0);
      chk("rst_mid_valid", out_valid, (i >= 8) ? 1 : 0);
      if (i >= 8) chk("rst_mid_re", out_re, 1000);
    end

    // randomized stream with gaps and occasional resync
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 8);
      s = v && ($urandom_range(0, 59) == 0);
      cycle(v, (i == 0) ? 1'b1 : s,
            int'($urandom_range(0, 40000)) - 20000,
            int'($urandom_range(0, 40000)) - 20000);
    end

    // saturation mode
    for (int i = 0; i < 33; i++) sat_x[i] = 0;
    sat_x[0] = 32767; sat_x[8] = 32767; sat_x[16] = -32768; sat_x[24] = 32767;
    for (int i = 0; i < 33; i++) begin
      cycle_s(1'b1, i == 0, sat_x[i]);
      if (i == 8)  chk("sat_sum_pos", s_out_re, 32767);
      if (i == 9)  chk("sat_sum_zero", s_out_re, 0);
      if (i == 16) chk("sat_diff_zero", s_out_re, 0);
      if (i == 24) chk("sat_sum_mixed", s_out_re, -1);
      if (i == 32) chk("sat_diff_neg", s_out_re, -32768);
      if (i >= 8) chk("sat_valid", s_out_valid, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
